// File: rtl/branch_target_predictor_pkg.sv
// +--------------------------------------------------------------------------+
// | branch_target_predictor_pkg : BTB entry layout and 2-bit counter states  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

package branch_target_predictor_pkg;

  localparam int BTB_XLEN     = 32;
  localparam int BTB_TAG_BITS = 10;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_cnt_e;

  localparam bp_cnt_e BP_CNT_ALLOC = WEAK_T;

  typedef struct packed {
    logic                    valid;
    logic                    is_jal;
    logic [BTB_TAG_BITS-1:0] tag;
    bp_cnt_e                 cnt;
    logic [BTB_XLEN-1:0]     target;
  } btb_entry_t;

endpackage

`default_nettype wire

// File: rtl/branch_target_predictor_sat_counter2.sv
// +--------------------------------------------------------------------------+
// | sat_counter2 : combinational next state of a 2-bit saturating counter    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module sat_counter2
  import branch_target_predictor_pkg::*;
(
  input  bp_cnt_e i_cnt,
  input  logic    i_taken,
  output bp_cnt_e o_cnt
);

  always_comb begin
    o_cnt = i_cnt;
    if (i_taken) begin
      if (i_cnt != STRONG_T) o_cnt = bp_cnt_e'(i_cnt + 2'd1);
    end else begin
      if (i_cnt != STRONG_NT) o_cnt = bp_cnt_e'(i_cnt - 2'd1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_target_predictor.sv
// +--------------------------------------------------------------------------+
// | branch_target_predictor : direct-mapped BTB, 1-cycle registered lookup   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 10
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_fetch_valid,
  input  logic            i_fetch_stall,
  input  logic [XLEN-1:0] i_fetch_pc,
  output logic            o_predict_hit,
  output logic            o_predict_taken,
  output logic [XLEN-1:0] o_predict_target,
  input  logic            i_update_valid,
  input  logic [XLEN-1:0] i_update_pc,
  input  logic            i_update_is_branch,
  input  logic            i_update_is_jal,
  input  logic            i_update_taken,
  input  logic [XLEN-1:0] i_update_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + TAG_BITS + 1;

  logic [IDX_W-1:0]    f_idx, u_idx;
  logic [TAG_BITS-1:0] f_tag, u_tag;

  assign f_idx = i_fetch_pc[IDX_W+1:2];
  assign u_idx = i_update_pc[IDX_W+1:2];
  assign f_tag = i_fetch_pc[TAG_HI:TAG_LO];
  assign u_tag = i_update_pc[TAG_HI:TAG_LO];

  logic unused_pc_bits;
  generate
    if (TAG_HI + 1 < XLEN) begin : g_pc_upper
      assign unused_pc_bits = ^{i_fetch_pc[XLEN-1:TAG_HI+1], i_update_pc[XLEN-1:TAG_HI+1],
                                i_fetch_pc[1:0], i_update_pc[1:0]};
    end else begin : g_pc_exact
      assign unused_pc_bits = ^{i_fetch_pc[1:0], i_update_pc[1:0]};
    end
  endgenerate

  logic                valid_q  [ENTRIES];
  logic                valid_d  [ENTRIES];
  logic                is_jal_q [ENTRIES];
  logic                is_jal_d [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  bp_cnt_e             cnt_q    [ENTRIES];
  bp_cnt_e             cnt_d    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [XLEN-1:0]     target_d [ENTRIES];

  logic            hit_q, hit_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] pred_target_q, pred_target_d;

  logic    f_hit, u_hit;
  bp_cnt_e cnt_nxt;

  sat_counter2 u_sat_counter2 (
    .i_cnt   (cnt_q[u_idx]),
    .i_taken (i_update_taken),
    .o_cnt   (cnt_nxt)
  );

  // Lookup reads the current (pre-update) arrays: read-before-write on index collision.
  always_comb begin
    f_hit         = i_fetch_valid && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    hit_d         = hit_q;
    taken_d       = taken_q;
    pred_target_d = pred_target_q;
    if (!i_fetch_stall) begin
      hit_d         = f_hit;
      taken_d       = f_hit && ((cnt_q[f_idx] inside {WEAK_T, STRONG_T}) || is_jal_q[f_idx]);
      pred_target_d = f_hit ? target_q[f_idx] : '0;
    end
  end

  always_comb begin
    valid_d  = valid_q;
    is_jal_d = is_jal_q;
    tag_d    = tag_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    if (i_update_valid) begin
      if (i_update_is_jal) begin
        valid_d[u_idx]  = 1'b1;
        is_jal_d[u_idx] = 1'b1;
        tag_d[u_idx]    = u_tag;
        cnt_d[u_idx]    = STRONG_T;
        target_d[u_idx] = i_update_target;
      end else if (i_update_is_branch) begin
        if (u_hit) begin
          cnt_d[u_idx]    = cnt_nxt;
          is_jal_d[u_idx] = 1'b0;
          if (i_update_taken) target_d[u_idx] = i_update_target;
        end else if (i_update_taken) begin
          valid_d[u_idx]  = 1'b1;
          is_jal_d[u_idx] = 1'b0;
          tag_d[u_idx]    = u_tag;
          cnt_d[u_idx]    = BP_CNT_ALLOC;
          target_d[u_idx] = i_update_target;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= STRONG_NT;
      end
      hit_q         <= 1'b0;
      taken_q       <= 1'b0;
      pred_target_q <= '0;
    end else begin
      valid_q       <= valid_d;
      cnt_q         <= cnt_d;
      hit_q         <= hit_d;
      taken_q       <= taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  // Payload fields are only observed through a valid entry, so they need no reset.
  always_ff @(posedge i_clk) begin
    is_jal_q <= is_jal_d;
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign o_predict_hit    = hit_q;
  assign o_predict_taken  = taken_q;
  assign o_predict_target = pred_target_q;

`ifndef SYNTHESIS
  a_branch_jal_exclusive : assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_update_valid && i_update_is_branch && i_update_is_jal));
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
// +--------------------------------------------------------------------------+
// | tb_branch_target_predictor : directed vector table plus corner sequences |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid, fetch_stall;
  logic [31:0] fetch_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_is_branch, upd_is_jal, upd_taken;
  logic [31:0] upd_pc, upd_target;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_target_predictor #(.XLEN(32), .ENTRIES(64), .TAG_BITS(10)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_fetch_valid      (fetch_valid),
    .i_fetch_stall      (fetch_stall),
    .i_fetch_pc         (fetch_pc),
    .o_predict_hit      (pred_hit),
    .o_predict_taken    (pred_taken),
    .o_predict_target   (pred_target),
    .i_update_valid     (upd_valid),
    .i_update_pc        (upd_pc),
    .i_update_is_branch (upd_is_branch),
    .i_update_is_jal    (upd_is_jal),
    .i_update_taken     (upd_taken),
    .i_update_target    (upd_target)
  );

  typedef struct {
    logic        fv;
    logic        fs;
    logic [31:0] fpc;
    logic        uv;
    logic [31:0] upc;
    logic        br;
    logic        jal;
    logic        tk;
    logic [31:0] utgt;
    logic        eh;
    logic        et;
    logic [31:0] etgt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic fv, input logic fs, input logic [31:0] fpc,
                              input logic uv, input logic [31:0] upc, input logic br,
                              input logic jal, input logic tk, input logic [31:0] utgt,
                              input logic eh, input logic et, input logic [31:0] etgt);
    vec_t v;
    v.fv = fv; v.fs = fs; v.fpc = fpc;
    v.uv = uv; v.upc = upc; v.br = br; v.jal = jal; v.tk = tk; v.utgt = utgt;
    v.eh = eh; v.et = et; v.etgt = etgt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    fetch_valid   = v.fv;
    fetch_stall   = v.fs;
    fetch_pc      = v.fpc;
    upd_valid     = v.uv;
    upd_pc        = v.upc;
    upd_is_branch = v.br;
    upd_is_jal    = v.jal;
    upd_taken     = v.tk;
    upd_target    = v.utgt;
  endtask

  task automatic check(input string name, input logic eh, input logic et, input logic [31:0] etgt);
    n_tests++;
    if (pred_hit !== eh || pred_taken !== et || pred_target !== etgt) begin
      n_fail++;
      $display("FAIL %s: got hit=%0b taken=%0b target=%h, expected hit=%0b taken=%0b target=%h",
               name, pred_hit, pred_taken, pred_target, eh, et, etgt);
    end
  endtask

  task automatic step_check(input string name, input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check(name, v.eh, v.et, v.etgt);
  endtask

  initial begin
    rst = 1'b1;
    drive(mk(0,0,0, 0,0,0,0,0,0, 0,0,0));
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Columns: fetch valid/stall/pc, update valid/pc/branch/jal/taken/target, expected hit/taken/target
    vq.push_back(mk(1,0,32'h100, 0,32'h0,  0,0,0,32'h0,  0,0,32'h0));
    vq.push_back(mk(0,0,32'h0,   1,32'h100,1,0,1,32'h80, 0,0,32'h0));
    vq.push_back(mk(1,0,32'h100, 0,32'h0,  0,0,0,32'h0,  1,1,32'h80));
    vq.push_back(mk(1,0,32'h100, 1,32'h100,1,0,0,32'h44, 1,1,32'h80));
    vq.push_back(mk(1,0,32'h100, 1,32'h100,1,0,0,32'h44, 1,0,32'h80));
    vq.push_back(mk(1,0,32'h100, 1,32'h100,1,0,0,32'h44, 1,0,32'h80));
    vq.push_back(mk(1,0,32'h100, 0,32'h0,  0,0,0,32'h0,  1,0,32'h80));
    vq.push_back(mk(1,0,32'h100, 1,32'h100,1,0,1,32'h80, 1,0,32'h80));
    vq.push_back(mk(1,0,32'h100, 1,32'h100,1,0,1,32'h80, 1,0,32'h80));
    vq.push_back(mk(1,0,32'h100, 1,32'h100,1,0,1,32'h80, 1,1,32'h80));
    vq.push_back(mk(1,0,32'h100, 1,32'h100,1,0,1,32'h80, 1,1,32'h80));
    vq.push_back(mk(1,0,32'h100, 1,32'h100,1,0,0,32'h44, 1,1,32'h80));
    vq.push_back(mk(1,0,32'h100, 1,32'h100,1,0,0,32'h44, 1,1,32'h80));
    vq.push_back(mk(1,0,32'h100, 0,32'h0,  0,0,0,32'h0,  1,0,32'h80));
    vq.push_back(mk(1,0,32'h200, 0,32'h0,  0,0,0,32'h0,  0,0,32'h0));
    vq.push_back(mk(0,0,32'h0,   1,32'h200,1,0,1,32'h40, 0,0,32'h0));
    vq.push_back(mk(1,0,32'h200, 0,32'h0,  0,0,0,32'h0,  1,1,32'h40));
    vq.push_back(mk(1,0,32'h100, 0,32'h0,  0,0,0,32'h0,  0,0,32'h0));
    vq.push_back(mk(1,0,32'h304, 1,32'h304,1,0,1,32'h20, 0,0,32'h0));
    vq.push_back(mk(1,0,32'h304, 0,32'h0,  0,0,0,32'h0,  1,1,32'h20));
    vq.push_back(mk(0,0,32'h0,   1,32'h500,1,0,0,32'h99, 0,0,32'h0));
    vq.push_back(mk(1,0,32'h202, 0,32'h0,  0,0,0,32'h0,  1,1,32'h40));
    vq.push_back(mk(1,0,32'h500, 0,32'h0,  0,0,0,32'h0,  0,0,32'h0));
    vq.push_back(mk(1,0,32'h304, 1,32'h304,1,0,1,32'h24, 1,1,32'h20));
    vq.push_back(mk(1,0,32'h304, 0,32'h0,  0,0,0,32'h0,  1,1,32'h24));

    foreach (vq[i]) step_check($sformatf("vec%0d", i), vq[i]);

    // JAL allocation, then stall holds the prediction regardless of new lookups
    step_check("jal_write",  mk(0,0,32'h0,  1,32'h10,0,1,0,32'h400, 0,0,32'h0));
    step_check("jal_lookup", mk(1,0,32'h10, 0,32'h0, 0,0,0,32'h0,   1,1,32'h400));
    for (int k = 0; k < 3; k++)
      step_check($sformatf("stall_hold%0d", k), mk(k[0],1,32'h100, 0,32'h0,0,0,0,32'h0, 1,1,32'h400));

    // Reset asserted between edges must clear outputs immediately
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(0,0,0, 0,0,0,0,0,0, 0,0,0));

    step_check("relookup_after_reset", mk(1,0,32'h10, 0,32'h0,0,0,0,32'h0, 0,0,32'h0));
    step_check("jalr_update", mk(0,0,32'h0,  1,32'h20,0,0,1,32'h99, 0,0,32'h0));
    step_check("jalr_lookup", mk(1,0,32'h20, 0,32'h0, 0,0,0,32'h0,  0,0,32'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
